// File: rtl/pulse_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_gen_if -- configuration channel for pulse_gen.
//
// Carries one valid/ready handshake plus the configuration payload.
//   cfg_valid  : master -> slave, configuration offered
//   cfg_ready  : slave  -> master, pending slot free
//   cfg_high   : master -> slave, high time in clk cycles (CNT_W bits)
//   cfg_low    : master -> slave, low time in clk cycles (CNT_W bits)
//   cfg_count  : master -> slave, number of periods, 0 = continuous
// ---------------------------------------------------------------------------
interface pulse_gen_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [15:0]      cfg_count;

    modport master (
        output cfg_valid,
        output cfg_high,
        output cfg_low,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_high,
        input  cfg_low,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen -- programmable pulse / burst generator.
//
// A configuration (high time, low time, period count) is accepted into a
// one-deep pending slot through the cfg channel. When the generator starts a
// period from IDLE, or reaches a period boundary with enable still high, a
// pending configuration is promoted into the active registers. The output is
// high for active_high cycles, then low for active_low cycles. A nonzero
// count stops the generator after that many periods; count 0 runs until
// enable is dropped. Periods are never truncated by enable.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset
//   enable       : run request
//   cfg          : configuration channel (pulse_gen_if.slave)
//   signal_out   : generated waveform (registered)
//   period_start : one-cycle strobe, high in each cycle signal_out rises
//   busy         : high while the FSM is not IDLE
//   burst_done   : one-cycle strobe after the last period of a burst
//   cfg_err      : one-cycle strobe after a rejected (zero-time) config
// ---------------------------------------------------------------------------
module pulse_gen #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    pulse_gen_if.slave  cfg,
    output logic        signal_out,
    output logic        period_start,
    output logic        busy,
    output logic        burst_done,
    output logic        cfg_err
);

    // CLOCK_FREQ only documents the intended system clock; timing is
    // expressed purely in clk cycles. An empty block keeps it referenced.
    if (CLOCK_FREQ < 0) begin : g_freq_note
    end

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_reg;

    logic             pending_valid_reg;
    logic [CNT_W-1:0] pending_high_reg;
    logic [CNT_W-1:0] pending_low_reg;
    logic [15:0]      pending_count_reg;

    logic             active_valid_reg;
    logic [CNT_W-1:0] active_high_reg;
    logic [CNT_W-1:0] active_low_reg;
    logic [15:0]      remaining_reg;

    // Phase counter: holds the 1-based index of the current cycle within
    // the present phase, so the phase ends when it equals the phase length.
    // Its peak is therefore the phase length itself and it cannot wrap.
    logic [CNT_W-1:0] cnt_reg;

    logic             signal_out_reg;
    logic             period_start_reg;
    logic             busy_reg;
    logic             burst_done_reg;
    logic             cfg_err_reg;

    logic             xfer;
    logic             cfg_bad;

    assign cfg.cfg_ready = ~pending_valid_reg;
    assign xfer          = cfg.cfg_valid & ~pending_valid_reg;
    assign cfg_bad       = (cfg.cfg_high == CNT_ZERO) | (cfg.cfg_low == CNT_ZERO);

    assign signal_out    = signal_out_reg;
    assign period_start  = period_start_reg;
    assign busy          = busy_reg;
    assign burst_done    = burst_done_reg;
    assign cfg_err       = cfg_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            pending_valid_reg <= 1'b0;
            pending_high_reg  <= CNT_ZERO;
            pending_low_reg   <= CNT_ZERO;
            pending_count_reg <= 16'd0;
            active_valid_reg  <= 1'b0;
            active_high_reg   <= CNT_ZERO;
            active_low_reg    <= CNT_ZERO;
            remaining_reg     <= 16'd0;
            cnt_reg           <= CNT_ZERO;
            signal_out_reg    <= 1'b0;
            period_start_reg  <= 1'b0;
            busy_reg          <= 1'b0;
            burst_done_reg    <= 1'b0;
            cfg_err_reg       <= 1'b0;
        end else begin
            // Strobes default low; they are raised for one cycle below.
            period_start_reg <= 1'b0;
            burst_done_reg   <= 1'b0;
            cfg_err_reg      <= 1'b0;

            // Configuration intake. A transfer only happens while the slot
            // is empty, and promotion only happens while it is full, so the
            // two never touch pending state in the same cycle.
            if (xfer) begin
                if (cfg_bad) begin
                    cfg_err_reg <= 1'b1;
                end else begin
                    pending_valid_reg <= 1'b1;
                    pending_high_reg  <= cfg.cfg_high;
                    pending_low_reg   <= cfg.cfg_low;
                    pending_count_reg <= cfg.cfg_count;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (enable && (active_valid_reg || pending_valid_reg)) begin
                        state_reg        <= ST_HIGH;
                        signal_out_reg   <= 1'b1;
                        period_start_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                        cnt_reg          <= CNT_ONE;
                        if (pending_valid_reg) begin
                            active_high_reg   <= pending_high_reg;
                            active_low_reg    <= pending_low_reg;
                            remaining_reg     <= pending_count_reg;
                            active_valid_reg  <= 1'b1;
                            pending_valid_reg <= 1'b0;
                        end
                    end
                end

                ST_HIGH: begin
                    if (cnt_reg == active_high_reg) begin
                        state_reg      <= ST_LOW;
                        signal_out_reg <= 1'b0;
                        cnt_reg        <= CNT_ONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (cnt_reg != active_low_reg) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else if (remaining_reg == 16'd1) begin
                        // Last period of a finite burst: stop regardless of
                        // enable and forget the active configuration.
                        state_reg        <= ST_IDLE;
                        remaining_reg    <= 16'd0;
                        active_valid_reg <= 1'b0;
                        burst_done_reg   <= 1'b1;
                        busy_reg         <= 1'b0;
                        cnt_reg          <= CNT_ZERO;
                    end else begin
                        // Period boundary without burst end. remaining==0
                        // is continuous mode and is left untouched.
                        if (remaining_reg != 16'd0) begin
                            remaining_reg <= remaining_reg - 16'd1;
                        end
                        if (!enable) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            cnt_reg   <= CNT_ZERO;
                        end else begin
                            state_reg        <= ST_HIGH;
                            signal_out_reg   <= 1'b1;
                            period_start_reg <= 1'b1;
                            cnt_reg          <= CNT_ONE;
                            // Only a configuration that was already pending
                            // before this cycle is promoted; one arriving in
                            // this very cycle waits for the next boundary.
                            if (pending_valid_reg) begin
                                active_high_reg   <= pending_high_reg;
                                active_low_reg    <= pending_low_reg;
                                remaining_reg     <= pending_count_reg;
                                active_valid_reg  <= 1'b1;
                                pending_valid_reg <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    signal_out_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    cnt_reg        <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic signal_out, period_start, busy, burst_done, cfg_err;

    int compared   = 0;
    int mismatched = 0;

    pulse_gen_if #(.CNT_W(32)) cfg_bus ();

    pulse_gen #(
        .CLOCK_FREQ(50000000),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg         (cfg_bus),
        .signal_out  (signal_out),
        .period_start(period_start),
        .busy        (busy),
        .burst_done  (burst_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [31:0] h, input logic [31:0] l, input logic [15:0] c);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_high  = h;
        cfg_bus.cfg_low   = l;
        cfg_bus.cfg_count = c;
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_high  = '0;
        cfg_bus.cfg_low   = '0;
        cfg_bus.cfg_count = '0;
        tick();
        tick();
        check("rst_sig", signal_out, 0);
        check("rst_ps", period_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_ready", cfg_bus.cfg_ready, 1);
        rst = 1'b0;
        tick();

        // --- continuous 3/2 ---
        send_cfg(3, 2, 0);
        check("t1_ready_pend", cfg_bus.cfg_ready, 0);
        check("t1_sig_pre", signal_out, 0);
        enable = 1'b1;
        tick();
        check("t1_ready_promo", cfg_bus.cfg_ready, 1);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 15; i++) begin
            $display("t1 cycle %0d sig=%0b ps=%0b", i, signal_out, period_start);
            check("t1_sig", signal_out, ((i % 5) < 3) ? 1 : 0);
            check("t1_ps", period_start, ((i % 5) == 0) ? 1 : 0);
            if (i < 14) tick();
        end
        enable = 1'b0;
        tick();
        check("t1_stop_busy", busy, 0);
        check("t1_stop_sig", signal_out, 0);

        // --- burst 2/2 x3 ---
        send_cfg(2, 2, 3);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            $display("t2 cycle %0d sig=%0b ps=%0b done=%0b", i, signal_out, period_start, burst_done);
            check("t2_sig", signal_out, ((i % 4) < 2) ? 1 : 0);
            check("t2_ps", period_start, ((i % 4) == 0) ? 1 : 0);
            check("t2_done", burst_done, 0);
            check("t2_busy", busy, 1);
            tick();
        end
        check("t2_end_done", burst_done, 1);
        check("t2_end_busy", busy, 0);
        check("t2_end_sig", signal_out, 0);
        tick();
        check("t2_after_done", burst_done, 0);
        check("t2_after_busy", busy, 0);
        tick();
        check("t2_norestart_busy", busy, 0);
        check("t2_norestart_sig", signal_out, 0);
        enable = 1'b0;

        // --- 4/4 running, 1/1 accepted mid-HIGH ---
        send_cfg(4, 4, 0);
        enable = 1'b1;
        tick();
        check("t3_c0_sig", signal_out, 1);
        tick();
        check("t3_c1_sig", signal_out, 1);
        check("t3_c1_ready", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_high  = 1;
        cfg_bus.cfg_low   = 1;
        cfg_bus.cfg_count = 0;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        for (int i = 2; i < 8; i++) begin
            $display("t3 cycle %0d sig=%0b ready=%0b", i, signal_out, cfg_bus.cfg_ready);
            check("t3_ready_low", cfg_bus.cfg_ready, 0);
            check("t3_sig", signal_out, (i < 4) ? 1 : 0);
            tick();
        end
        check("t3_c8_sig", signal_out, 1);
        check("t3_c8_ps", period_start, 1);
        check("t3_c8_ready", cfg_bus.cfg_ready, 1);
        tick();
        check("t3_c9_sig", signal_out, 0);
        check("t3_c9_ps", period_start, 0);
        tick();
        check("t3_c10_sig", signal_out, 1);
        check("t3_c10_ps", period_start, 1);
        enable = 1'b0;
        tick();
        check("t3_c11_sig", signal_out, 0);
        check("t3_c11_busy", busy, 1);
        tick();
        check("t3_c12_busy", busy, 0);

        // --- rejected configurations ---
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        enable = 1'b1;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_high  = 0;
        cfg_bus.cfg_low   = 5;
        cfg_bus.cfg_count = 0;
        tick();
        check("t4_err_h0", cfg_err, 1);
        check("t4_ready_h0", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_high = 5;
        cfg_bus.cfg_low  = 0;
        tick();
        check("t4_err_l0", cfg_err, 1);
        check("t4_ready_l0", cfg_bus.cfg_ready, 1);
        cfg_bus.cfg_valid = 1'b0;
        tick();
        check("t4_err_clr", cfg_err, 0);
        check("t4_busy", busy, 0);
        check("t4_sig", signal_out, 0);
        tick();
        check("t4_busy2", busy, 0);
        check("t4_sig2", signal_out, 0);
        check("t4_ps2", period_start, 0);
        enable = 1'b0;

        // --- enable dropped early in a 5/5 period ---
        send_cfg(5, 5, 0);
        enable = 1'b1;
        tick();
        check("t5_c0_sig", signal_out, 1);
        tick();
        enable = 1'b0;
        for (int i = 1; i < 10; i++) begin
            $display("t5 cycle %0d sig=%0b busy=%0b", i, signal_out, busy);
            check("t5_sig", signal_out, (i < 5) ? 1 : 0);
            check("t5_busy", busy, 1);
            tick();
        end
        check("t5_end_busy", busy, 0);
        check("t5_end_sig", signal_out, 0);
        check("t5_end_ps", period_start, 0);

        // --- reset mid-HIGH ---
        enable = 1'b1;
        tick();
        check("t6_c0_sig", signal_out, 1);
        tick();
        check("t6_c1_sig", signal_out, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_sig", signal_out, 0);
        check("t6_rst_ready", cfg_bus.cfg_ready, 1);
        check("t6_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("t6_post_busy", busy, 0);
        check("t6_post_sig", signal_out, 0);

        // --- transfer in the boundary cycle, 1/1 running ---
        send_cfg(1, 1, 0);
        tick();
        check("t7_c0_sig", signal_out, 1);
        tick();
        check("t7_c1_sig", signal_out, 0);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_high  = 2;
        cfg_bus.cfg_low   = 2;
        cfg_bus.cfg_count = 0;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        check("t7_c2_sig", signal_out, 1);
        check("t7_c2_ps", period_start, 1);
        check("t7_c2_ready", cfg_bus.cfg_ready, 0);
        tick();
        check("t7_c3_sig", signal_out, 0);
        check("t7_c3_ready", cfg_bus.cfg_ready, 0);
        tick();
        check("t7_c4_sig", signal_out, 1);
        check("t7_c4_ps", period_start, 1);
        check("t7_c4_ready", cfg_bus.cfg_ready, 1);
        tick();
        check("t7_c5_sig", signal_out, 1);
        check("t7_c5_ps", period_start, 0);
        tick();
        check("t7_c6_sig", signal_out, 0);
        tick();
        check("t7_c7_sig", signal_out, 0);
        tick();
        check("t7_c8_sig", signal_out, 1);
        check("t7_c8_ps", period_start, 1);
        enable = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
